// File: rtl/fetch_buffer_if.sv
// Signal bundle between the fetch stage, the instruction bus and the decode stage.
// master is the fetch_buffer side; slave is the bus/decode environment side.
interface fetch_buffer_if;
  logic        flush;
  logic [31:0] new_pc;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_busy;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  flush, new_pc, imem_rdata, imem_busy, instr_ready,
    output imem_ren, imem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output flush, new_pc, imem_rdata, imem_busy, instr_ready,
    input  imem_ren, imem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch: owns the PC, keeps one word read outstanding, and queues {pc, word} for decode.
// Words appear on instr one cycle after bus completion; fetching pauses while the queue is full.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic           CLK,
  input  logic           nRST,
  fetch_buffer_if.master bus
);
  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t           state, state_d;
  logic [31:0]      fetch_pc, fetch_pc_d;
  logic [31:0]      stale_addr, stale_addr_d;
  logic [CNT_W-1:0] count, count_after_pop;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  entry_t           mem [DEPTH];
  logic             push, pop;

  // A flush wins over any pop requested in the same cycle.
  assign pop             = (count != '0) && bus.instr_ready && !bus.flush;
  assign count_after_pop = count - (pop ? ONE : '0);

  always_comb begin
    state_d      = state;
    fetch_pc_d   = fetch_pc;
    stale_addr_d = stale_addr;
    push         = 1'b0;
    if (bus.flush) begin
      fetch_pc_d = {bus.new_pc[31:2], 2'b00};
      unique case (state)
        IDLE: state_d = REQ;
        REQ: begin
          // The bus cannot abort a stalled read, so remember its address and drain it.
          if (bus.imem_busy) begin
            stale_addr_d = fetch_pc;
            state_d      = DISCARD;
          end else begin
            state_d = REQ;
          end
        end
        DISCARD: state_d = bus.imem_busy ? DISCARD : REQ;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (count_after_pop < FULL) state_d = REQ;
        end
        REQ: begin
          if (!bus.imem_busy) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc + 32'd4;
            state_d    = ((count_after_pop + ONE) < FULL) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (!bus.imem_busy) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      stale_addr    <= '0;
      bus.imem_ren  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      state         <= state_d;
      fetch_pc      <= fetch_pc_d;
      stale_addr    <= stale_addr_d;
      bus.imem_ren  <= (state_d != IDLE);
      bus.imem_addr <= (state_d == DISCARD) ? stale_addr_d : fetch_pc_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr].pc   <= fetch_pc;
        mem[wr_ptr].word <= bus.imem_rdata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = mem[rd_ptr].word;
  assign bus.instr_pc    = mem[rd_ptr].pc;
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage that sits directly upstream of the decode/control stage.
- Owns the fetch PC and issues word reads on the instruction bus.
- Queues returned instruction words, each with its PC, in a small FIFO; the decode stage pops entries with a valid/ready handshake.
- Handles pipeline redirects (flush + new PC), including discarding an in-flight bus read that cannot be aborted.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0200, fetch address after reset.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  redirect request: drop all queued/in-flight instructions.
- new_pc  in  32  redirect target, sampled when flush=1.
- imem_ren  out  1  instruction bus read request.
- imem_addr  out  32  instruction bus word address.
- imem_rdata  in  32  read data; valid in the cycle imem_ren && !imem_busy.
- imem_busy  in  1  bus stall; a transaction completes in the cycle imem_ren=1 and imem_busy=0.
- instr  out  32  head-of-FIFO instruction word.
- instr_pc  out  32  PC of the head entry.
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  decode accepts the head entry (pop when instr_valid && instr_ready).

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0.
  - imem_ren=0, imem_addr=RESET_PC, instr_valid=0; instr and instr_pc are don't-care but must be 0.
- Bus rule: once imem_ren is asserted, imem_ren and imem_addr stay stable until completion. At most one outstanding read.
- States:
  - IDLE: imem_ren=0. Go to REQ when count<DEPTH (after a pop, if any, in the same cycle). First request is the first cycle after nRST releases.
  - REQ: imem_ren=1, imem_addr=fetch_pc. On completion without flush: push {fetch_pc, imem_rdata}, fetch_pc+=4 (wraps modulo 2^32). Stay in REQ if post-update count<DEPTH, else go to IDLE.
  - DISCARD: imem_ren=1, imem_addr=stale_addr (register). On completion: no push, go to REQ (the FIFO is necessarily not full).
- flush=1, highest priority in every state:
  - FIFO cleared (count=0, pointers=0); the pop in that cycle is ignored; fetch_pc=new_pc.
  - In IDLE: go to REQ.
  - In REQ, imem_busy=1: stale_addr=current fetch_pc, go to DISCARD.
  - In REQ, imem_busy=0: completing data dropped, stay in REQ at new_pc.
  - In DISCARD: stay in DISCARD (stale_addr unchanged, fetch_pc=new_pc), unless completing that cycle, then go to REQ.
- FIFO:
  - Registered storage; outputs come from the head entry and count!=0.
  - Data completing in cycle N is visible on instr/instr_valid in cycle N+1 (1-cycle latency, no bypass).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop when empty: ignored.
  - Push when full: cannot occur by construction; the bench asserts this.
- No assumptions on instruction content; alignment is always a 4-byte word. fetch_pc[1:0] is forced to 0 on redirect.

Test Plan:
- Reset, imem_busy=0, instr_ready=1:
  - imem_ren=1, imem_addr=0x200 in the first cycle after nRST rises.
  - Consecutive cycles show instr_pc 0x200, 0x204, 0x208, with instr matching the rdata returned.
- instr_ready=0, DEPTH=2:
  - After 2 completions, count=2 and imem_ren drops to 0.
  - Raising instr_ready for one cycle pops 0x200; next cycle imem_ren=1 with addr 0x208.
- Flush with imem_busy=1 during a read of 0x204, new_pc=0x1000:
  - imem_addr stays 0x204 until busy drops, and that data is not pushed.
  - Next request is addr 0x1000; first instr_valid shows instr_pc=0x1000.
- Flush in the same cycle as a completion, new_pc=0x3000:
  - The completing word is dropped and instr_valid=0 next cycle.
  - imem_addr=0x3000 the following cycle.
- fetch_pc=0xFFFF_FFFC completes, then the next request is addr 0x0000_0000 (wrap).
- nRST pulsed low mid-transaction while busy=1:
  - imem_ren=0, instr_valid=0, and count=0 immediately (asynchronously).
  - Restart at 0x200.
